// File: rtl/instr_queue.sv
// Instruction queue: circular FIFO of {pc, instr} entries with first-word
// fall-through on the head, flush for redirects, and no enqueue/dequeue bypass.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [WIDTH-1:0]         enq_data,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [WIDTH-1:0]         deq_data,
  input  logic                     deq_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [AW:0]      headQ, headD;
  logic [AW:0]      tailQ, tailD;
  logic             fullW, emptyW;
  logic             enqFire, deqFire;

  // Full when indices match but the wrap bits differ; empty when pointers match.
  assign emptyW  = (headQ == tailQ);
  assign fullW   = (headQ[AW-1:0] == tailQ[AW-1:0]) && (headQ[AW] != tailQ[AW]);

  assign enq_ready = !fullW;
  assign deq_valid = !emptyW;
  assign enqFire   = enq_valid && !fullW;
  assign deqFire   = deq_ready && !emptyW;

  assign deq_data = memQ[headQ[AW-1:0]];
  assign count    = tailQ - headQ;

  always_comb begin
    headD = headQ;
    tailD = tailQ;
    if (flush) begin
      headD = '0;
      tailD = '0;
    end else begin
      if (enqFire) tailD = tailQ + PtrOne;
      if (deqFire) headD = headQ + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headQ <= '0;
      tailQ <= '0;
    end else begin
      headQ <= headD;
      tailQ <= tailD;
    end
  end

  // Storage is never cleared; a write during a flush lands beyond the reset pointers and is unreachable.
  always_ff @(posedge clk) begin
    if (enqFire) memQ[tailQ[AW-1:0]] <= enq_data;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the FIFO contents.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             enqValid;
  logic [WIDTH-1:0] enqData;
  logic             enqReady;
  logic             deqValid;
  logic [WIDTH-1:0] deqData;
  logic             deqReady;
  logic [3:0]       count;

  int totalChecks;
  int badChecks;

  logic [WIDTH-1:0] model[$];

  instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enqValid),
    .enq_data  (enqData),
    .enq_ready (enqReady),
    .deq_valid (deqValid),
    .deq_data  (deqData),
    .deq_ready (deqReady),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs at the falling edge, compare outputs with the
  // model, advance the model by what the rising edge should do.
  task automatic doCycle(input logic doCheck, input logic r, input logic f,
                         input logic ev, input logic [WIDTH-1:0] ed, input logic dr);
    logic canEnq;
    logic canDeq;
    rst      = r;
    flush    = f;
    enqValid = ev;
    enqData  = ed;
    deqReady = dr;
    #1;
    if (doCheck) begin
      totalChecks++;
      if (count !== 4'(model.size())) begin
        badChecks++;
        $display("[TB] FAIL count: got %0d want %0d at %0t", count, model.size(), $time);
      end
      totalChecks++;
      if (deqValid !== (model.size() != 0)) begin
        badChecks++;
        $display("[TB] FAIL deq_valid: got %b want %b at %0t", deqValid, model.size() != 0, $time);
      end
      totalChecks++;
      if (enqReady !== (model.size() < DEPTH)) begin
        badChecks++;
        $display("[TB] FAIL enq_ready: got %b want %b at %0t", enqReady, model.size() < DEPTH, $time);
      end
      if (model.size() != 0) begin
        totalChecks++;
        if (deqData !== model[0]) begin
          badChecks++;
          $display("[TB] FAIL deq_data: got %h want %h at %0t", deqData, model[0], $time);
        end
      end
    end
    if (r || f) begin
      model.delete();
    end else begin
      canEnq = ev && (model.size() < DEPTH);
      canDeq = dr && (model.size() != 0);
      if (canDeq) void'(model.pop_front());
      if (canEnq) model.push_back(ed);
    end
    @(negedge clk);
  endtask

  task automatic enqN(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b1, base + WIDTH'(i), 1'b0);
  endtask

  task automatic test_reset();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] want;
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(8, 64'h1);
    for (int i = 0; i < 8; i++) begin
      want = WIDTH'(i + 1);
      totalChecks++;
      if (deqValid !== 1'b1 || deqData !== want) begin
        badChecks++;
        $display("[TB] FAIL drain_order: got %b/%h want 1/%h", deqValid, deqData, want);
      end
      doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(5, 64'h100);
    for (int i = 0; i < 5; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    enqN(6, 64'h200);
    totalChecks++;
    if (count !== 4'd6) begin
      badChecks++;
      $display("[TB] FAIL wrap_count: got %0d want 6", count);
    end
    for (int i = 0; i < 6; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_simultaneous();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(3, 64'h300);
    for (int i = 0; i < 10; i++)
      doCycle(1'b1, 1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
    totalChecks++;
    if (count !== 4'd3) begin
      badChecks++;
      $display("[TB] FAIL simul_count: got %0d want 3", count);
    end
  endtask

  task automatic test_full_with_deq();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(8, 64'h400);
    doCycle(1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b1);
    totalChecks++;
    if (count !== 4'd7 || enqReady !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL full_deq: got count=%0d rdy=%b want count=7 rdy=1", count, enqReady);
    end
    for (int i = 0; i < 8; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_flush();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(5, 64'h500);
    doCycle(1'b1, 1'b0, 1'b1, 1'b1, 64'hF1F1, 1'b1);
    totalChecks++;
    if (count !== 4'd0 || deqValid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush: got count=%0d vld=%b want count=0 vld=0", count, deqValid);
    end
    enqN(2, 64'h600);
    for (int i = 0; i < 3; i++) doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    doCycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    enqN(4, 64'h700);
    doCycle(1'b1, 1'b1, 1'b0, 1'b1, 64'h7777, 1'b1);
    totalChecks++;
    if (count !== 4'd0 || enqReady !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL reset_mid: got count=%0d rdy=%b want count=0 rdy=1", count, enqReady);
    end
    doCycle(1'b1, 1'b0, 1'b0, 1'b1, 64'hAB, 1'b0);
    totalChecks++;
    if (deqValid !== 1'b1 || deqData !== 64'hAB) begin
      badChecks++;
      $display("[TB] FAIL reset_mid_head: got %b/%h want 1/ab", deqValid, deqData);
    end
    doCycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic r, f, ev, dr;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 50);
      doCycle(1'b1, r, f, ev, {$urandom, $urandom}, dr);
    end
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1; flush = 1'b0; enqValid = 1'b0; enqData = '0; deqReady = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_full_with_deq();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 64, entry width ({pc[31:0], instr[31:0]}).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard all entries (mispredict/redirect).
REQ-006 SHALL have port enq_valid, input, 1, upstream offers an entry.
REQ-007 SHALL have port enq_data, input, WIDTH, entry being offered.
REQ-008 SHALL have port enq_ready, output, 1, queue can accept an entry this cycle.
REQ-009 SHALL have port deq_valid, output, 1, head entry is valid.
REQ-010 SHALL have port deq_data, output, WIDTH, head entry contents.
REQ-011 SHALL have port deq_ready, input, 1, downstream consumes the head this cycle.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, number of valid entries.

Function
REQ-013 SHALL be a circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits; MSB is the wrap bit.
REQ-014 SHALL define empty as head == tail, and full as equal index bits with differing wrap bits.
REQ-015 SHALL drive enq_ready = !full and deq_valid = !empty, both derived from registered state only, with no combinational path from any input.
REQ-016 SHALL drive deq_data combinationally from the head entry (first-word fall-through); deq_data is don't-care when deq_valid = 0.
REQ-017 SHALL enqueue on enq_valid && enq_ready: write the entry at tail; tail increments by 1.
REQ-018 SHALL dequeue on deq_valid && deq_ready: head increments by 1.
REQ-019 SHALL wrap pointer index bits from DEPTH-1 to 0 and toggle the wrap bit.
REQ-020 SHALL allow simultaneous enqueue and dequeue in one cycle when neither full nor empty; count is unchanged.
REQ-021 SHALL, when full, reject enqueue even if a dequeue occurs in the same cycle (no pass-through); the enq_ready = 0 cycle is observed.
REQ-022 SHALL, when empty, provide no bypass; an entry enqueued in cycle t is visible on deq_valid/deq_data in cycle t+1 (latency 1).
REQ-023 SHALL drive count = tail - head (modulo 2^($clog2(DEPTH)+1)), range 0..DEPTH.
REQ-024 SHALL, on flush, set head = tail = 0 at the next edge; flush overrides any enqueue or dequeue in the same cycle, and that enqueue is lost.
REQ-025 SHALL keep a dequeue with deq_ready = 1 and deq_valid = 0 as no state change.
REQ-026 SHALL hold enq_data sampling to the handshake cycle only; storage contents need not be cleared.

Reset
REQ-027 SHALL, with rst = 1 at a rising edge, set head = tail = 0, giving count = 0, deq_valid = 0, enq_ready = 1 in the following cycle.
REQ-028 SHALL give rst priority over flush, enqueue and dequeue; reset mid-operation discards all entries.
REQ-029 SHALL NOT require entry storage to be reset.

Verification
REQ-030 SHALL cover fill/drain: 8 enqueues of 0x1..0x8 with deq_ready = 0 -> count = 8, enq_ready = 0; then deq_ready = 1 -> 0x1..0x8 delivered in order over 8 cycles; count = 0.
REQ-031 SHALL cover wrap-around: 5 enqueues, 5 dequeues, then 6 enqueues -> data order preserved across the index 7 to 0 wrap; count = 6.
REQ-032 SHALL cover simultaneous enqueue/dequeue: with count = 3, enq_valid = deq_ready = 1 for 10 cycles -> count stays 3, and outputs follow FIFO order.
REQ-033 SHALL cover full with dequeue: with count = 8, enq_valid = deq_ready = 1 -> the enqueue is rejected; next cycle count = 7, enq_ready = 1.
REQ-034 SHALL cover flush: with count = 5, flush = 1 together with enq_valid = 1 -> next cycle count = 0, deq_valid = 0, and the flushed-cycle entry never appears.
REQ-035 SHALL cover reset mid-stream: rst = 1 with count = 4 -> next cycle count = 0, enq_ready = 1; the following enqueue of 0xAB appears as the head one cycle later.
